// File: rtl/dpe_row_sequencer.sv
// Row sequencer for the dot-product engine: loads x, feeds 32 weights per row, starts, collects y.
// Latency: x/weight accept to BRAM write/eng_en 1 cycle; eng_done to y_valid 1 cycle.
// Backpressure: y_valid holds until y_ready; inputs accepted only in their state. Watchdog: DPE_SEQ_TIMEOUT_EN.
module dpe_row_sequencer #(
  parameter int N_BANKS     = 64,
  parameter int W_PER_ROW   = 32,
  parameter int ROW_W       = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ROW_W-1:0]   cmd_rows,
  input  logic [2:0]         cmd_dtype,
  input  logic               cmd_load_x,
  input  logic               x_in_valid,
  output logic               x_in_ready,
  input  logic [31:0]        x_in_data,
  input  logic               w_in_valid,
  output logic               w_in_ready,
  input  logic [15:0]        w_in_data,
  output logic               eng_en,
  output logic [15:0]        eng_weight,
  output logic [2:0]         eng_dtype,
  output logic               eng_start,
  output logic [3:0]         eng_x_wr_addr,
  output logic [31:0]        eng_x_wr_data,
  output logic [N_BANKS-1:0] eng_x_wr_en,
  input  logic [31:0]        eng_y,
  input  logic               eng_done,
  output logic               y_valid,
  input  logic               y_ready,
  output logic [31:0]        y_data,
  output logic [ROW_W-1:0]   y_row,
  output logic               busy,
  output logic               cmd_done,
  output logic               err_timeout
);

  localparam int KW = $clog2(N_BANKS);
  localparam int WW = $clog2(W_PER_ROW);
  localparam logic [N_BANKS-1:0] BANK0 = {{(N_BANKS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, LOAD_X, FEED_W, START, WAIT_DONE, EMIT} state_t;

  state_t           state;
  logic [KW-1:0]    k_cnt;
  logic [WW-1:0]    w_cnt;
  logic [ROW_W-1:0] rows;
  logic [ROW_W-1:0] row_idx;

`ifdef DPE_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] t_cnt;
`else
  assign err_timeout = 1'b0;
`endif

  // The x BRAM is one element per bank, so only address 0 is ever written.
  assign eng_x_wr_addr = 4'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      k_cnt         <= '0;
      w_cnt         <= '0;
      rows          <= '0;
      row_idx       <= '0;
      cmd_ready     <= 1'b0;
      x_in_ready    <= 1'b0;
      w_in_ready    <= 1'b0;
      eng_en        <= 1'b0;
      eng_weight    <= '0;
      eng_dtype     <= '0;
      eng_start     <= 1'b0;
      eng_x_wr_data <= '0;
      eng_x_wr_en   <= '0;
      y_valid       <= 1'b0;
      y_data        <= '0;
      y_row         <= '0;
      busy          <= 1'b0;
      cmd_done      <= 1'b0;
`ifdef DPE_SEQ_TIMEOUT_EN
      t_cnt         <= '0;
      err_timeout   <= 1'b0;
`endif
    end else begin
      eng_x_wr_en <= '0;
      eng_en      <= 1'b0;
      eng_start   <= 1'b0;
      cmd_done    <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_ready && cmd_valid) begin
            rows      <= cmd_rows;
            eng_dtype <= cmd_dtype;
            k_cnt     <= '0;
            w_cnt     <= '0;
            row_idx   <= '0;
`ifdef DPE_SEQ_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            if (cmd_load_x) begin
              cmd_ready  <= 1'b0;
              busy       <= 1'b1;
              x_in_ready <= 1'b1;
              state      <= LOAD_X;
            end else if (cmd_rows != '0) begin
              cmd_ready  <= 1'b0;
              busy       <= 1'b1;
              w_in_ready <= 1'b1;
              state      <= FEED_W;
            end else begin
              cmd_done   <= 1'b1;
            end
          end
        end
        LOAD_X: begin
          if (x_in_valid) begin
            eng_x_wr_en   <= BANK0 << k_cnt;
            eng_x_wr_data <= x_in_data;
            k_cnt         <= k_cnt + 1'b1;
            if (k_cnt == KW'(N_BANKS - 1)) begin
              x_in_ready <= 1'b0;
              if (rows == '0) begin
                cmd_done  <= 1'b1;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
                state     <= IDLE;
              end else begin
                w_in_ready <= 1'b1;
                state      <= FEED_W;
              end
            end
          end
        end
        FEED_W: begin
          if (w_in_valid) begin
            eng_weight <= w_in_data;
            eng_en     <= 1'b1;
            w_cnt      <= w_cnt + 1'b1;
            if (w_cnt == WW'(W_PER_ROW - 1)) begin
              w_cnt      <= '0;
              w_in_ready <= 1'b0;
              state      <= START;
            end
          end
        end
        START: begin
          eng_start <= 1'b1;
          state     <= WAIT_DONE;
`ifdef DPE_SEQ_TIMEOUT_EN
          t_cnt     <= '0;
`endif
        end
        WAIT_DONE: begin
          // A done coincident with our own start pulse belongs to a previous operation.
          if (eng_done && !eng_start) begin
            y_data  <= eng_y;
            y_row   <= row_idx;
            y_valid <= 1'b1;
            state   <= EMIT;
          end
`ifdef DPE_SEQ_TIMEOUT_EN
          else if (t_cnt == TW'(TIMEOUT_CYC - 1)) begin
            err_timeout <= 1'b1;
            cmd_done    <= 1'b1;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            t_cnt <= t_cnt + 1'b1;
          end
`endif
        end
        EMIT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            if (row_idx != rows - 1'b1) begin
              row_idx    <= row_idx + 1'b1;
              w_in_ready <= 1'b1;
              state      <= FEED_W;
            end else begin
              cmd_done  <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpe_row_sequencer.sv
// Scoreboard bench for dpe_row_sequencer with a behavioural engine and x BRAM model.
module tb_dpe_row_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_load_x;
  logic [7:0]  cmd_rows;
  logic [2:0]  cmd_dtype;
  logic        x_in_valid, x_in_ready;
  logic [31:0] x_in_data;
  logic        w_in_valid, w_in_ready;
  logic [15:0] w_in_data;
  logic        eng_en, eng_start, eng_done;
  logic [15:0] eng_weight;
  logic [2:0]  eng_dtype;
  logic [3:0]  eng_x_wr_addr;
  logic [31:0] eng_x_wr_data, eng_y;
  logic [63:0] eng_x_wr_en;
  logic        y_valid, y_ready;
  logic [31:0] y_data;
  logic [7:0]  y_row;
  logic        busy, cmd_done, err_timeout;

  dpe_row_sequencer #(.N_BANKS(64), .W_PER_ROW(32), .ROW_W(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rows(cmd_rows),
    .cmd_dtype(cmd_dtype), .cmd_load_x(cmd_load_x),
    .x_in_valid(x_in_valid), .x_in_ready(x_in_ready), .x_in_data(x_in_data),
    .w_in_valid(w_in_valid), .w_in_ready(w_in_ready), .w_in_data(w_in_data),
    .eng_en(eng_en), .eng_weight(eng_weight), .eng_dtype(eng_dtype), .eng_start(eng_start),
    .eng_x_wr_addr(eng_x_wr_addr), .eng_x_wr_data(eng_x_wr_data), .eng_x_wr_en(eng_x_wr_en),
    .eng_y(eng_y), .eng_done(eng_done),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_row(y_row),
    .busy(busy), .cmd_done(cmd_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  row;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_y [3] = '{32'h4280_0000, 32'h4300_0000, 32'h4340_0000};
  logic [31:0] bram [64];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, start_cnt = 0, wr_cnt = 0, en_cnt = 0;
  int wr_k = 0, stall_n = 0, start_cyc = 0, done_cyc = 0;
  bit hang_mode = 0, done_at_start = 0, stray_req = 0;
  logic [2:0] cur_dtype = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic any_out();
    return |{cmd_ready, x_in_ready, w_in_ready, eng_en, eng_weight, eng_dtype, eng_start,
             eng_x_wr_addr, eng_x_wr_data, eng_x_wr_en, y_valid, y_data, y_row, busy,
             cmd_done, err_timeout};
  endfunction

  function automatic logic [31:0] int_to_fp(input int v);
    logic [31:0] u, r;
    int m;
    if (v <= 0) return 32'hDEAD_BEEF;
    u = 32'(v);
    m = 0;
    for (int i = 0; i < 24; i++) if (u[i]) m = i;
    r = '0;
    r[30:23] = 8'(127 + m);
    r[22:0]  = 23'(u << (23 - m));
    return r;
  endfunction

  // Engine + x BRAM model: int8 lanes dotted with x, valid only when every x element is 1.0.
  initial begin
    int acc, dly;
    bit pending, x_ok;
    logic [31:0] res;
    logic [63:0] one;
    acc = 0; dly = 0; pending = 0; res = '0; one = 64'd1;
    eng_done = 1'b0;
    eng_y = '0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (!rstn) begin
        acc = 0;
        pending = 0;
      end else begin
        if (eng_x_wr_en != '0) begin
          chk("x_wr_onehot", eng_x_wr_en, one << wr_k);
          chk("x_wr_addr", 64'(eng_x_wr_addr), 64'd0);
          if (wr_k < 64) bram[wr_k] = eng_x_wr_data;
          wr_k++;
          wr_cnt++;
        end
        if (eng_en) begin
          en_cnt++;
          acc += int'($signed(eng_weight[7:0])) + int'($signed(eng_weight[15:8]));
        end
        if (eng_start) begin
          start_cnt++;
          start_cyc = cyc;
          chk("eng_dtype", 64'(eng_dtype), 64'(cur_dtype));
          x_ok = 1;
          for (int i = 0; i < 64; i++) if (bram[i] !== 32'h3F80_0000) x_ok = 0;
          res = x_ok ? int_to_fp(acc) : 32'hDEAD_BEEF;
          acc = 0;
          pending = !hang_mode;
          dly = 3;
          if (done_at_start) begin
            eng_done = 1'b1;
            eng_y = 32'hBAD0_0001;
          end
        end else if (pending) begin
          if (dly == 0) begin
            eng_done = 1'b1;
            eng_y = res;
            pending = 0;
          end else dly--;
        end else if (stray_req && w_in_ready) begin
          eng_done = 1'b1;
          eng_y = 32'hBAD0_0002;
          stray_req = 0;
        end
      end
    end
  end

  // Result monitor: stalls y_ready stall_n cycles per result, then pops and compares.
  initial begin
    int stall_cnt;
    exp_t e;
    stall_cnt = 0;
    y_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!rstn) begin
        y_ready = 1'b0;
        stall_cnt = 0;
      end else if (y_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_y: y_data 0x%0h y_row %0d with no result expected", y_data, y_row);
          y_ready = 1'b1;
        end else if (stall_cnt < stall_n) begin
          y_ready = 1'b0;
          stall_cnt++;
          chk("y_data_stalled", 64'(y_data), 64'(exp_q[0].data));
        end else begin
          y_ready = 1'b1;
          e = exp_q.pop_front();
          chk("y_data", 64'(y_data), 64'(e.data));
          chk("y_row", 64'(y_row), 64'(e.row));
          stall_cnt = 0;
        end
      end else begin
        y_ready = 1'b0;
      end
    end
  end

  task automatic send_cmd(input int rows, input logic [2:0] dtype, input bit load_x);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!cmd_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid  = 1'b1;
    cmd_rows   = 8'(rows);
    cmd_dtype  = dtype;
    cmd_load_x = load_x;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic run_cmd(input int rows, input logic [2:0] dtype, input bit load_x,
                         input int stall, input bit bubbles, input bit stray, input bit hang);
    int d0, s0, w0, e0, xi, wi, budget;
    exp_t e;
    stall_n = stall;
    hang_mode = hang;
    cur_dtype = dtype;
    if (!hang) for (int r = 0; r < rows; r++) begin
      e.data = exp_y[r];
      e.row  = 8'(r);
      exp_q.push_back(e);
    end
    d0 = done_cnt; s0 = start_cnt; w0 = wr_cnt; e0 = en_cnt; wr_k = 0;
    send_cmd(rows, dtype, load_x);
    chk("busy_after_accept", 64'(busy), 64'(rows != 0 || load_x));
    chk("cmd_ready_while_busy", 64'(cmd_ready), 64'(!(rows != 0 || load_x)));
    chk("err_timeout_cleared", 64'(err_timeout), 64'd0);
    if (load_x) begin
      xi = 0; budget = 0;
      while (xi < 64 && budget < 1000) begin
        x_in_valid = !(bubbles && $urandom_range(0, 3) == 0);
        x_in_data  = 32'h3F80_0000;
        if (x_in_valid && x_in_ready) xi++;
        @(negedge clk);
        budget++;
      end
      x_in_valid = 1'b0;
    end
    wi = 0; budget = 0;
    while (wi < rows * 32 && done_cnt == d0 && budget < 5000) begin
      w_in_valid = !(bubbles && $urandom_range(0, 3) == 0);
      w_in_data  = 16'(((wi / 32) + 1) * 257);
      if (w_in_valid && w_in_ready) begin
        wi++;
        if (stray && wi == 10) stray_req = 1;
      end
      @(negedge clk);
      budget++;
    end
    w_in_valid = 1'b0;
    budget = 0;
    while (done_cnt == d0 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    repeat (2) @(negedge clk);
    chk("cmd_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("results_outstanding", 64'(exp_q.size()), 64'd0);
    chk("eng_start_count", 64'(start_cnt - s0), 64'(hang ? 1 : rows));
    chk("x_write_count", 64'(wr_cnt - w0), load_x ? 64'd64 : 64'd0);
    chk("eng_en_count", 64'(en_cnt - e0), 64'(hang ? 32 : 32 * rows));
    chk("idle_after_cmd", 64'({busy, cmd_ready}), 64'b01);
  endtask

  initial begin
    int wi, budget;
    rstn = 1'b0;
    cmd_valid = 1'b0; cmd_rows = '0; cmd_dtype = '0; cmd_load_x = 1'b0;
    x_in_valid = 1'b0; x_in_data = '0; w_in_valid = 1'b0; w_in_data = '0;
    for (int i = 0; i < 64; i++) bram[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", 64'(any_out()), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);
    chk("busy_after_reset", 64'(busy), 64'd0);

    // Single row with x load.
    run_cmd(1, 3'd2, 1'b1, 0, 1'b0, 1'b0, 1'b0);

    // Three rows on reused x, stalled results, done coincident with start ignored.
    done_at_start = 1;
    run_cmd(3, 3'd2, 1'b0, 5, 1'b0, 1'b0, 1'b0);
    done_at_start = 0;

    // Bubbled streams plus a stray done during weight feed.
    run_cmd(2, 3'd2, 1'b1, 1, 1'b1, 1'b1, 1'b0);

    // Zero rows with x load: writes only.
    run_cmd(0, 3'd1, 1'b1, 0, 1'b0, 1'b0, 1'b0);

`ifdef DPE_SEQ_TIMEOUT_EN
    run_cmd(2, 3'd2, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("err_timeout_set", 64'(err_timeout), 64'd1);
    chk("timeout_latency", 64'(done_cyc - start_cyc), 64'd16);
    run_cmd(1, 3'd2, 1'b0, 0, 1'b0, 1'b0, 1'b0);
`else
    chk("err_timeout_tied", 64'(err_timeout), 64'd0);
`endif

    // Reset in the middle of a weight feed, then a clean command.
    send_cmd(1, 3'd2, 1'b0);
    wi = 0; budget = 0;
    while (wi < 10 && budget < 200) begin
      w_in_valid = 1'b1;
      w_in_data  = 16'h0101;
      if (w_in_ready) wi++;
      @(negedge clk);
      budget++;
    end
    w_in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("midreset_outputs_zero", 64'(any_out()), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_cmd(1, 3'd3, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, still running at t=%0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
